// File: rtl/conv33_pkg.sv
// conv33_pkg: constants and helpers shared by the conv33 datapath blocks.
//   KSIZE              - kernel edge length (3)
//   DEFAULT_DATA_WIDTH - default pixel width
//   win_idx()          - bit offset of window element (r,c) in a flattened window
//   cnt_width()        - counter width needed to count 0..n-1
package conv33_pkg;

  localparam int unsigned KSIZE              = 3;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  function automatic int unsigned win_idx(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned dw);
    return (KSIZE * r + c) * dw;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv33_line_buffer.sv
// conv33_line_buffer: single-port line memory, asynchronous read, synchronous write.
// Ports:
//   clk   - clock
//   we    - write enable (write lands on the rising edge)
//   addr  - shared read/write address
//   wdata - write data
//   rdata - data currently stored at addr; during a write cycle this is the
//           old contents, so a same-address access is read-before-write.
module conv33_line_buffer
  import conv33_pkg::*;
#(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv33_input_window.sv
// conv33_input_window: turns a raster-order pixel stream into 3x3 windows for
// every unpadded output position, using two line buffers (rows r-2 and r-1).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   in_valid    - pixel accept strobe (no backpressure)
//   in_data     - pixel, raster order
//   out_valid   - out_window holds a fresh window this cycle
//   out_window  - element (r,c) at [DATA_WIDTH*(3r+c) +: DATA_WIDTH], r=0 top, c=0 left
//   frame_done  - one-cycle pulse with the last window of a frame; only active
//                 when CONV33_INPUT_FRAME_DONE_EN is defined, otherwise tied 0.
module conv33_input_window
  import conv33_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  output logic [9*DATA_WIDTH-1:0]     out_window,
  output logic                        frame_done
);

  localparam int unsigned CW = cnt_width(IMG_W);
  localparam int unsigned RW = cnt_width(IMG_H);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic [DATA_WIDTH-1:0] t;
  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] win [KSIZE][KSIZE];

  // A pixel presented while reset is asserted is dropped entirely.
  assign accept   = in_valid && !rst;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  conv33_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH), .AW(CW)) lb_top (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (m),
    .rdata (t)
  );

  conv33_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH), .AW(CW)) lb_mid (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (m)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      for (int unsigned r = 0; r < KSIZE; r++)
        for (int unsigned c = 0; c < KSIZE; c++)
          win[r][c] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        for (int unsigned r = 0; r < KSIZE; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= t;
        win[1][2] <= m;
        win[2][2] <= in_data;

        // Stale line-buffer rows and columns carried over a row boundary
        // are both hidden by this gate.
        out_valid <= (row >= RW'(2)) && (col >= CW'(2));

        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_comb begin
    out_window = '0;
    for (int unsigned r = 0; r < KSIZE; r++)
      for (int unsigned c = 0; c < KSIZE; c++)
        out_window[win_idx(r, c, DATA_WIDTH) +: DATA_WIDTH] = win[r][c];
  end

`ifdef CONV33_INPUT_FRAME_DONE_EN
  logic frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) frame_done_q <= 1'b0;
    else     frame_done_q <= in_valid && row_last && col_last;
  end

  assign frame_done = frame_done_q;
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_conv33_input_window.sv
module tb_conv33_input_window;

`ifdef CONV33_INPUT_FRAME_DONE_EN
  localparam bit FD_EN = 1'b1;
`else
  localparam bit FD_EN = 1'b0;
`endif

  typedef logic [72:0] exp_t;   // {frame_done, window}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv4 = 1'b0, iv28 = 1'b0;
  logic [7:0]  d4 = '0, d28 = '0;
  logic        ov4, ov28, fd4, fd28;
  logic [71:0] w4, w28;

  always #5 clk = ~clk;

  conv33_input_window #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_data(d4),
    .out_valid(ov4), .out_window(w4), .frame_done(fd4)
  );

  conv33_input_window #(.DATA_WIDTH(8), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk(clk), .rst(rst), .in_valid(iv28), .in_data(d28),
    .out_valid(ov28), .out_window(w28), .frame_done(fd28)
  );

  int checks = 0;
  int errors = 0;

  exp_t        q4[$], q28[$];
  logic [71:0] seen4[$];
  logic [7:0]  img4  [0:3][0:3];
  logic [7:0]  img28 [0:27][0:27];
  int          r4 = 0, c4 = 0, r28 = 0, c28 = 0;
  int          nwin4 = 0, nwin28 = 0, nfd28 = 0;
  logic        exp_ov4 = 1'b0, exp_ov28 = 1'b0;
  logic        exp_q4 = 1'b0, exp_q28 = 1'b0;

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a [9]);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = a[k][7:0];
    return v;
  endfunction

  // Drive one cycle on the 4x4 DUT and update the reference model.
  task automatic px4(input logic v, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    iv4 = v; d4 = d; exp_ov4 = 1'b0;
    if (v && !rst) begin
      img4[r4][c4] = d;
      if (r4 >= 2 && c4 >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e[8*(3*i+j) +: 8] = img4[r4-2+i][c4-2+j];
        e[72] = FD_EN && r4 == 3 && c4 == 3;
        q4.push_back(e);
        exp_ov4 = 1'b1;
      end
      if (c4 == 3) begin c4 = 0; r4 = (r4 == 3) ? 0 : r4 + 1; end
      else c4 = c4 + 1;
    end
  endtask

  task automatic px28(input logic v, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    iv28 = v; d28 = d; exp_ov28 = 1'b0;
    if (v && !rst) begin
      img28[r28][c28] = d;
      if (r28 >= 2 && c28 >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e[8*(3*i+j) +: 8] = img28[r28-2+i][c28-2+j];
        e[72] = FD_EN && r28 == 27 && c28 == 27;
        q28.push_back(e);
        exp_ov28 = 1'b1;
      end
      if (c28 == 27) begin c28 = 0; r28 = (r28 == 27) ? 0 : r28 + 1; end
      else c28 = c28 + 1;
    end
  endtask

  always @(posedge clk) begin
    exp_q4  <= exp_ov4;
    exp_q28 <= exp_ov28;
  end

  always @(negedge clk) begin
    check("ov4", ov4, exp_q4);
    if (ov4 === 1'b1) begin
      nwin4++;
      seen4.push_back(w4);
      if (q4.size() == 0) begin
        checks++; errors++;
        $error("FAIL win4_unexpected observed=%h expected=none", w4);
      end else check("win4", {fd4, w4}, q4.pop_front());
    end else check("fd4_idle", fd4, 1'b0);
  end

  always @(negedge clk) begin
    check("ov28", ov28, exp_q28);
    if (fd28 === 1'b1) nfd28++;
    if (ov28 === 1'b1) begin
      nwin28++;
      if (q28.size() == 0) begin
        checks++; errors++;
        $error("FAIL win28_unexpected observed=%h expected=none", w28);
      end else check("win28", {fd28, w28}, q28.pop_front());
    end else check("fd28_idle", fd28, 1'b0);
  end

  initial begin
    int base;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ov4", ov4, 1'b0);
    check("rst_w4", w4, '0);
    check("rst_fd4", fd4, 1'b0);
    check("rst_ov28", ov28, 1'b0);
    check("rst_w28", w28, '0);
    rst = 1'b0;

    // Test 1: continuous 4x4 frame
    seen4.delete(); base = nwin4;
    for (int i = 0; i < 16; i++) px4(1'b1, 8'(i));
    repeat (3) px4(1'b0, 8'h00);
    check("t1_count", nwin4 - base, 4);
    check("t1_first", seen4[0], pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    check("t1_last", seen4[3], pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));

    // Test 2: same frame with in_valid toggling
    seen4.delete(); base = nwin4;
    for (int i = 0; i < 16; i++) begin
      px4(1'b1, 8'(i));
      px4(1'b0, 8'hEE);
    end
    repeat (3) px4(1'b0, 8'h00);
    check("t2_count", nwin4 - base, 4);
    check("t2_first", seen4[0], pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    check("t2_last", seen4[3], pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));

    // Test 3: back-to-back frames
    seen4.delete(); base = nwin4;
    for (int i = 0; i < 16; i++) px4(1'b1, 8'(i));
    for (int i = 0; i < 16; i++) px4(1'b1, 8'(100 + i));
    repeat (3) px4(1'b0, 8'h00);
    check("t3_count", nwin4 - base, 8);
    check("t3_f2_first", seen4[4], pack9('{100, 101, 102, 104, 105, 106, 108, 109, 110}));
    check("t3_f2_last", seen4[7], pack9('{105, 106, 107, 109, 110, 111, 113, 114, 115}));

    // Test 4: reset after pixel 9, pixel presented during reset is dropped
    for (int i = 0; i < 10; i++) px4(1'b1, 8'(200 + i));
    @(negedge clk);
    rst = 1'b1; iv4 = 1'b1; d4 = 8'h55; exp_ov4 = 1'b0;
    r4 = 0; c4 = 0;
    @(negedge clk);
    check("t4_rst_ov", ov4, 1'b0);
    check("t4_rst_w", w4, '0);
    check("t4_rst_fd", fd4, 1'b0);
    rst = 1'b0; iv4 = 1'b0;
    seen4.delete(); base = nwin4;
    for (int i = 0; i < 16; i++) px4(1'b1, 8'(i));
    repeat (3) px4(1'b0, 8'h00);
    check("t4_count", nwin4 - base, 4);
    check("t4_first", seen4[0], pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    check("t4_last", seen4[3], pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));

    // Test 5: full 28x28 frame on the default-size instance
    base = nwin28;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        px28(1'b1, 8'((r * 5 + c * 3 + 1) & 255));
    repeat (3) px28(1'b0, 8'h00);
    check("t5_count", nwin28 - base, 676);
    check("t5_fd_pulses", nfd28, FD_EN ? 1 : 0);

    repeat (2) @(negedge clk);
    check("q4_drained", q4.size(), 0);
    check("q28_drained", q28.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv33_input_window.md
# conv33_input_window

Front end of the 3x3 convolution datapath. It accepts a raster-order pixel stream, holds the two previous image rows in on-chip line buffers, and presents a complete 3x3 window to the conv33 compute stage for every valid (unpadded) output position. It is the input-side counterpart of the conv33 output buffer/controller that drains results from the compute stage.

## Interface
- `DATA_WIDTH`, default 8: pixel width in bits.
- `IMG_W`, default 28: image width in pixels; must be ≥3.
- `IMG_H`, default 28: image height in pixels; must be ≥3.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: pixel accept strobe. There is no backpressure; every asserted cycle consumes one pixel.
- `in_data` input DATA_WIDTH: pixel, in raster order (row-major, row 0 first).
- `out_valid` output 1: `out_window` holds a valid window this cycle.
- `out_window` output 9*DATA_WIDTH: element (r,c) sits at bits [DATA_WIDTH*(3r+c) +: DATA_WIDTH]. r=0 is the oldest row (top); c=0 is the leftmost column.
- `frame_done` output 1: last-window pulse. It is functional only with `CONV33_INPUT_FRAME_DONE_EN`.

## Operation
- Counters:
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both advance only on `in_valid`.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next pixel starts a new frame; there are no idle cycles between frames.
- Line buffers:
  - `lb_top` holds row-2 and `lb_mid` holds row-1, each IMG_W deep, indexed by `col`.
  - On accept, read `t=lb_top[col]` and `m=lb_mid[col]`.
  - In the same cycle, write `lb_top[col]<=m` and `lb_mid[col]<=in_data`.
  - Read-before-write applies at the same address.
- Window registers:
  - On accept, the 3x3 array shifts left by one column.
  - The new column c=2 is {r0=t, r1=m, r2=in_data}.
- Output rule:
  - `out_valid` is registered high the cycle after an accept with row≥2 and col≥2. Otherwise it is low.
  - `out_window` updates only on accept and holds its value otherwise.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- Stale data:
  - Line buffers are never cleared. Rows 0–1 of a new frame carry the previous frame's data, but the row≥2 gate suppresses them.
  - Window columns carried across a row boundary are likewise suppressed by the col≥2 gate.
- `in_valid` gaps: the state is frozen and the output is unaffected; `out_valid` is low during gaps.

## Timing
- Latency: one cycle from the accept of pixel (r,c) to `out_valid` for the window whose bottom-right element is (r,c).
- Throughput: one window per cycle with continuous `in_valid`.
- Reset values:
  - `out_valid=0`, `out_window=0`, `frame_done=0`.
  - `row=0`, `col=0`, window registers 0.
  - Line-buffer contents are not reset (don't-care).
- Reset mid-frame:
  - The next accepted pixel is treated as (0,0).
  - No window is emitted until row 2, col 2 of the new frame.
  - A pixel presented in the reset cycle is dropped.
- Read/write on the same buffer entry in the same cycle returns old data.

## Configuration
- `CONV33_INPUT_FRAME_DONE_EN` defined:
  - `frame_done` pulses high for exactly one cycle, coincident with the `out_valid` of the window at (IMG_H-1, IMG_W-1).
  - The pulse is registered, with reset value 0.
- Not defined: `frame_done` is tied to 0, and no extra logic is generated.

## Structure
- Shared package `conv33_pkg`:
  - `KSIZE=3` and the default `DATA_WIDTH`.
  - The window element index function (3r+c)*DATA_WIDTH, also used by the compute stage.
  - Counter width derivation via `$clog2(IMG_W)` / `$clog2(IMG_H)`.
- Sub-module `conv33_line_buffer`: single-port read-before-write memory (DEPTH, WIDTH parameters), instantiated twice.
- The counters, window shift array, and output registers stay in the top module.

## Test plan
- IMG_W=IMG_H=4, pixels 0..15 continuous:
  - The first `out_valid` comes one cycle after pixel 10 is accepted, with window = {0,1,2,4,5,6,8,9,10}.
  - Exactly 4 windows are produced, the last = {5,6,7,9,10,11,13,14,15}.
- Same stream with `in_valid` toggling 1/0:
  - Identical window sequence and count.
  - `out_valid` is never high in the cycle after a low `in_valid`.
- Two back-to-back frames (values 0..15 then 100..115):
  - Frame 2's first window = {100,101,102,104,105,106,108,109,110}.
  - No window is emitted during frame 2 rows 0–1.
- `rst` asserted after pixel 9, then a new frame 0..15:
  - Outputs return to 0 at the reset edge.
  - The output sequence is identical to the first test.
- Build with `CONV33_INPUT_FRAME_DONE_EN`, 28x28 frame:
  - 676 windows.
  - `frame_done` is high only on the 676th `out_valid` cycle.
- Build without the macro: `frame_done` stays 0 throughout.
